mem_ctrl: RTL and testbench

Bus master placed directly upstream of the 1024×32 single-port `memory` block. It accepts word read and write requests from the core over a valid/ready handshake. It generates the active-low `CS_`/`RD_`/`WR_` strobes and address, and owns the write side of the shared tristate `Data` bus. It returns read data with a one-cycle `Ack` pulse and inserts a programmable number of wait states. It also inserts a guaranteed idle turnaround cycle between transactions so the controller and the memory never drive `Data` at the same time.

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_ctrl_if.sv | 61 ++++++
 rtl/mem_wait_cnt.sv | 47 ++++
 rtl/mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// ------------
// Shared types and constants for the memory bus controller slice.
// Contents:
//   DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
//                             (1024 x 32 memory)
//   WAIT_W                  : width of the wait-state counter
//   MAX_WAIT                : largest wait-state count the counter can hold
//   ctrlState_e             : controller state encoding
//   waitLoad()              : turns an integer wait-state count into a
//                             counter load value
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    localparam int WAIT_W = 4;
    localparam int unsigned MAX_WAIT = (1 << WAIT_W) - 1;

    // The READ -> DONE and WRITE -> DONE transitions each flip one bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ctrlState_e;

    // A parameter above the counter range saturates rather than wrapping.
    // Wrapping would silently shorten the access.
    function automatic logic [WAIT_W-1:0] waitLoad(input int unsigned waitStates);
        logic [WAIT_W-1:0] loadVal;
        if (waitStates > MAX_WAIT) begin
            loadVal = {WAIT_W{1'b1}};
        end else begin
            loadVal = waitStates[WAIT_W-1:0];
        end
        return loadVal;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if
// -----------
// Groups the request handshake from the core and the memory strobe and
// address lines driven by the controller.
// The shared tristate Data bus is not part of this interface. It stays a
// plain inout net on the controller so that the controller and the memory
// resolve it on one ordinary wire.
// Signals:
//   Req, ReqWr, ReqAddr, ReqWData : request from the core
//   ReqRdy                        : controller can accept a request
//   Ack, RData                    : completion pulse and read data
//   Addr, CS_, RD_, WR_           : memory address and active-low strobes
// Modports:
//   master : the controller's view
//   slave  : the environment's view (core plus memory)
interface mem_ctrl_if import mem_ctrl_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              Req;
    logic              ReqWr;
    logic [ADDR_W-1:0] ReqAddr;
    logic [DATA_W-1:0] ReqWData;
    logic              ReqRdy;
    logic              Ack;
    logic [DATA_W-1:0] RData;
    logic [ADDR_W-1:0] Addr;
    logic              CS_;
    logic              RD_;
    logic              WR_;

    modport master (
        input  Req,
        input  ReqWr,
        input  ReqAddr,
        input  ReqWData,
        output ReqRdy,
        output Ack,
        output RData,
        output Addr,
        output CS_,
        output RD_,
        output WR_
    );

    modport slave (
        output Req,
        output ReqWr,
        output ReqAddr,
        output ReqWData,
        input  ReqRdy,
        input  Ack,
        input  RData,
        input  Addr,
        input  CS_,
        input  RD_,
        input  WR_
    );

endinterface

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt
// ------------
// Loadable down-counter that times the wait states of one memory access.
// The counter stops at zero and does not wrap. This lets the controller
// hold a request at zero without guarding the decrement itself.
// Ports:
//   Clk       : rising-edge clock
//   Rst_      : asynchronous active-low reset, clears the count
//   load_i    : load loadVal_i on the next edge (has priority over dec_i)
//   loadVal_i : value to load
//   dec_i     : decrement on the next edge while the count is non-zero
//   zero_o    : count is currently zero
module mem_wait_cnt import mem_ctrl_pkg::*; (
    input  logic              Clk,
    input  logic              Rst_,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] loadVal_i,
    input  logic              dec_i,
    output logic              zero_o
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Next count. A load wins over a decrement, and the count stays at zero
    // once it gets there.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WAIT_W'(1);
        end
    end

    // Count register. Reset returns it to zero.
    always_ff @(posedge Clk or negedge Rst_) begin
        if (!Rst_) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// --------
// Bus master that sits in front of a single-port asynchronous-read memory.
// It accepts one word read or write from the core at a time and runs it as
// follows:
//   IDLE  -> READ/WRITE : the strobes are held low for WAIT_STATES+1 cycles
//         -> DONE       : the strobes are high, Data is released and Ack
//                         pulses for one cycle
//         -> IDLE
// The DONE cycle is a guaranteed turnaround. The controller's write drive
// and the memory's read drive are therefore always separated by at least
// one cycle in which neither side drives Data.
// Ports:
//   Clk   : rising-edge clock
//   Rst_  : asynchronous active-low reset
//   bus   : request handshake and memory strobes/address (mem_ctrl_if.master)
//   Data  : shared tristate data bus. The controller drives it only in
//           WRITE and samples it at the final READ edge.
module mem_ctrl import mem_ctrl_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 0
) (
    input  logic              Clk,
    input  logic              Rst_,
    mem_ctrl_if.master        bus,
    inout  wire  [DATA_W-1:0] Data
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = waitLoad(WAIT_STATES);

    ctrlState_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_q;
    logic              csN_q;
    logic              rdN_q;
    logic              wrN_q;

    logic              accept;
    logic              inAccess;
    logic              cntDec;
    logic              cntZero;

    // A request is taken only in IDLE. Anything presented in the other
    // states is ignored and never queued.
    assign accept   = (state_q == IDLE) && bus.Req;
    assign inAccess = (state_q == READ) || (state_q == WRITE);
    assign cntDec   = inAccess && !cntZero;

    // Wait-state timer. It is loaded on the accept edge and counted down
    // during the access phase. The access ends on the edge at which the
    // timer is already zero.
    mem_wait_cnt waitCnt (
        .Clk       (Clk),
        .Rst_      (Rst_),
        .load_i    (accept),
        .loadVal_i (WAIT_LOAD),
        .dec_i     (cntDec),
        .zero_o    (cntZero)
    );

    // Main controller FSM.
    // The strobes and Ack are registered here, alongside the state, and not
    // decoded from the two state bits. The DONE -> IDLE transition flips
    // both state bits, so a decode of them could glitch CS_; flops cannot.
    // Reset clears everything asynchronously, so an interrupted access drops
    // its strobes at once, never acknowledges, and loses its read data.
    always_ff @(posedge Clk or negedge Rst_) begin
        if (!Rst_) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            csN_q   <= 1'b1;
            rdN_q   <= 1'b1;
            wrN_q   <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Req) begin
                        addr_q  <= bus.ReqAddr;
                        wdata_q <= bus.ReqWData;
                        csN_q   <= 1'b0;
                        if (bus.ReqWr) begin
                            state_q <= WRITE;
                            wrN_q   <= 1'b0;
                        end else begin
                            state_q <= READ;
                            rdN_q   <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (cntZero) begin
                        rdata_q <= Data;
                        ack_q   <= 1'b1;
                        csN_q   <= 1'b1;
                        rdN_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                WRITE: begin
                    if (cntZero) begin
                        ack_q   <= 1'b1;
                        csN_q   <= 1'b1;
                        wrN_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    csN_q   <= 1'b1;
                    rdN_q   <= 1'b1;
                    wrN_q   <= 1'b1;
                end
            endcase
        end
    end

    // Write drive, taken straight from the state register. READ and WRITE
    // are mutually exclusive states, so the controller can never drive Data
    // while the memory is being read.
    assign Data = (state_q == WRITE) ? wdata_q : {DATA_W{1'bz}};

    assign bus.ReqRdy = (state_q == IDLE);
    assign bus.Ack    = ack_q;
    assign bus.RData  = rdata_q;
    assign bus.Addr   = addr_q;
    assign bus.CS_    = csN_q;
    assign bus.RD_    = rdN_q;
    assign bus.WR_    = wrN_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
// -----------
// Three controller instances with WAIT_STATES of 0, 3 and 2. Each instance
// is paired with a behavioural 1024x32 asynchronous-read memory on its own
// tristate Data net.
// Expected behaviour comes from a word-level reference:
//   - per-instance arrays of memory contents and last-read data
//   - latency and strobe-width formulas expressed in terms of WAIT_STATES
module tb_mem_ctrl;

    localparam int NI = 3;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int WS [NI] = '{0, 3, 2};

    logic Clk = 1'b0;

    // Free-running clock, period 10.
    always #5 Clk = ~Clk;

    logic [NI-1:0]         rstN;
    logic [NI-1:0]         req;
    logic [NI-1:0]         reqWr;
    logic [NI-1:0]         bdWe;
    logic [NI-1:0][AW-1:0] reqAddr;
    logic [NI-1:0][AW-1:0] bdAddr;
    logic [NI-1:0][DW-1:0] reqWData;
    logic [NI-1:0][DW-1:0] bdData;

    wire  [NI-1:0]         reqRdy;
    wire  [NI-1:0]         ack;
    wire  [NI-1:0]         csN;
    wire  [NI-1:0]         rdN;
    wire  [NI-1:0]         wrN;
    wire  [NI-1:0][AW-1:0] addr;
    wire  [NI-1:0][DW-1:0] rData;
    wire  [NI-1:0][DW-1:0] busData;

    logic [DW-1:0] refMem   [NI][1024];
    bit            refValid [NI][1024];
    logic [DW-1:0] refLast  [NI];

    int vectors     = 0;
    int miscompares = 0;

    // One controller plus memory per instance.
    // The memory drives Data combinationally while CS_ and RD_ are low. It
    // commits Data on every edge while CS_ and WR_ are low. A backdoor port
    // preloads words without going through the controller.
    for (genvar g = 0; g < NI; g++) begin : gInst
        mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        wire  [DW-1:0] data;
        logic [DW-1:0] mem [1024];

        assign bus.Req      = req[g];
        assign bus.ReqWr    = reqWr[g];
        assign bus.ReqAddr  = reqAddr[g];
        assign bus.ReqWData = reqWData[g];
        assign reqRdy[g]    = bus.ReqRdy;
        assign ack[g]       = bus.Ack;
        assign rData[g]     = bus.RData;
        assign addr[g]      = bus.Addr;
        assign csN[g]       = bus.CS_;
        assign rdN[g]       = bus.RD_;
        assign wrN[g]       = bus.WR_;
        assign busData[g]   = data;

        mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS[g])) dut (
            .Clk  (Clk),
            .Rst_ (rstN[g]),
            .bus  (bus.master),
            .Data (data)
        );

        assign data = (!bus.CS_ && !bus.RD_) ? mem[bus.Addr] : {DW{1'bz}};

        always @(posedge Clk) begin
            if (bdWe[g]) begin
                mem[bdAddr[g]] <= bdData[g];
            end else if (!bus.CS_ && !bus.WR_) begin
                mem[bus.Addr] <= data;
            end
        end
    end

    // Any hang ends the run with a visible failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every vector and reports a miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the edge.
    // On every cycle and every instance, RD_ and WR_ must never both be low.
    task automatic tick();
        @(posedge Clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("rdWrOverlap%0d", i), 32'(!rdN[i] && !wrN[i]), 32'd0);
        end
    endtask

    // One isolated transaction on instance i, observed over its whole span.
    // When noisy is set, Req stays high with random address/direction
    // through the access phase. Those requests must be ignored.
    task automatic applyStimulus(input int i, input bit wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input bit noisy);
        int w;
        int waitCyc;
        int ackCnt;
        int ackEdge;
        int strobeLow;
        int strobeBad;
        int rdyLow;
        int addrBad;
        int turnBad;
        int dataBad;
        logic [DW-1:0] capData;
        w = WS[i];
        ackCnt = 0; ackEdge = -1; strobeLow = 0; strobeBad = 0;
        rdyLow = 0; addrBad = 0; turnBad = 0; dataBad = 0; capData = '0;
        waitCyc = 0;
        while (!reqRdy[i] && waitCyc < 50) begin
            tick();
            waitCyc++;
        end
        checkOutput($sformatf("rdyBeforeReq%0d", i), 32'(reqRdy[i]), 32'd1);
        req[i] = 1'b1; reqWr[i] = wr; reqAddr[i] = a; reqWData[i] = d;
        tick();
        // Cycle cyc lies between edge cyc and edge cyc+1, counted from the
        // accept edge.
        for (int cyc = 0; cyc < w + 4; cyc++) begin
            req[i]      = noisy && (cyc <= w);
            reqWr[i]    = 1'($urandom);
            reqAddr[i]  = AW'($urandom);
            reqWData[i] = $urandom;
            if (!csN[i] && !(wr ? wrN[i] : rdN[i])) strobeLow++;
            if (wr ? !rdN[i] : !wrN[i]) strobeBad++;
            if (!csN[i] && addr[i] !== a) addrBad++;
            if (!reqRdy[i]) rdyLow++;
            if (!wr && !rdN[i] && busData[i] !== refMem[i][a]) dataBad++;
            if (cyc == w + 1 && !(csN[i] && rdN[i] && wrN[i])) turnBad++;
            if (ack[i]) begin
                ackCnt++;
                if (ackEdge < 0) begin
                    ackEdge = cyc + 1;
                    capData = rData[i];
                end
            end
            tick();
        end
        req[i] = 1'b0;
        checkOutput($sformatf("ackCount%0d", i), 32'(ackCnt), 32'd1);
        checkOutput($sformatf("ackEdge%0d", i), 32'(ackEdge), 32'(w + 2));
        checkOutput($sformatf("strobeLowCycles%0d", i), 32'(strobeLow), 32'(w + 1));
        checkOutput($sformatf("wrongStrobe%0d", i), 32'(strobeBad), 32'd0);
        checkOutput($sformatf("rdyLowCycles%0d", i), 32'(rdyLow), 32'(w + 2));
        checkOutput($sformatf("addrStable%0d", i), 32'(addrBad), 32'd0);
        checkOutput($sformatf("turnaround%0d", i), 32'(turnBad), 32'd0);
        if (wr) begin
            refMem[i][a]   = d;
            refValid[i][a] = 1'b1;
        end else begin
            checkOutput($sformatf("readBus%0d", i), 32'(dataBad), 32'd0);
            checkOutput($sformatf("readData%0d@%0h", i, a), capData, refMem[i][a]);
            refLast[i] = refMem[i][a];
        end
        checkOutput($sformatf("rdataHold%0d", i), rData[i], refLast[i]);
    endtask

    // Req held high for four writes to 0..3 followed by four reads back.
    // Transactions must be spaced WAIT_STATES+3 apart, each with exactly one
    // Ack and a strobes-high turnaround cycle.
    task automatic backToBack(input int i);
        int w;
        int ackCnt;
        int ackWrongPos;
        int turnBad;
        int waitCyc;
        logic [DW-1:0] got [4];
        w = WS[i];
        ackCnt = 0; ackWrongPos = 0; turnBad = 0; waitCyc = 0;
        for (int j = 0; j < 4; j++) got[j] = '1;
        while (!reqRdy[i] && waitCyc < 50) begin
            tick();
            waitCyc++;
        end
        req[i] = 1'b1; reqWr[i] = 1'b1; reqAddr[i] = '0; reqWData[i] = '0;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                reqWr[i]    = (k + 1 < 4);
                reqAddr[i]  = AW'((k + 1) % 4);
                reqWData[i] = DW'(k + 1);
            end else begin
                req[i] = 1'b0;
            end
            for (int c = 0; c < w + 3; c++) begin
                if (ack[i]) begin
                    ackCnt++;
                    if (c != w + 1) ackWrongPos++;
                    if (k >= 4) got[k - 4] = rData[i];
                end
                if (c == w + 1 && !(csN[i] && rdN[i] && wrN[i])) turnBad++;
                tick();
            end
        end
        checkOutput("b2bAckCount", 32'(ackCnt), 32'd8);
        checkOutput("b2bAckSpacing", 32'(ackWrongPos), 32'd0);
        checkOutput("b2bTurnaround", 32'(turnBad), 32'd0);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("b2bRead%0d", j), got[j], DW'(j));
            refMem[i][j]   = DW'(j);
            refValid[i][j] = 1'b1;
        end
        refLast[i] = DW'(3);
    endtask

    // Directed and random sequence.
    initial begin
        int ackSeen;
        rstN = '0; req = '0; reqWr = '0; bdWe = '0;
        reqAddr = '0; bdAddr = '0; reqWData = '0; bdData = '0;
        for (int i = 0; i < NI; i++) refLast[i] = '0;

        // Values held during reset.
        #12;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("rstRdy%0d", i), 32'(reqRdy[i]), 32'd1);
            checkOutput($sformatf("rstStrobes%0d", i), 32'({csN[i], rdN[i], wrN[i]}), 32'd7);
            checkOutput($sformatf("rstAddr%0d", i), 32'(addr[i]), 32'd0);
            checkOutput($sformatf("rstAck%0d", i), 32'(ack[i]), 32'd0);
            checkOutput($sformatf("rstRData%0d", i), rData[i], 32'd0);
        end
        tick();
        rstN = '1;
        tick();

        // Backdoor preload of the top word of instance 1.
        bdWe[1] = 1'b1; bdAddr[1] = 10'h3FF; bdData[1] = 32'h12345678;
        tick();
        bdWe[1] = 1'b0;
        refMem[1][10'h3FF]   = 32'h12345678;
        refValid[1][10'h3FF] = 1'b1;

        $display("[TB] basic write/read, no wait states");
        applyStimulus(0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0);
        applyStimulus(0, 1'b0, 10'h005, 32'h0, 1'b0);

        $display("[TB] three wait states, requester noise during access");
        applyStimulus(1, 1'b0, 10'h3FF, 32'h0, 1'b1);

        $display("[TB] back-to-back traffic");
        backToBack(0);

        $display("[TB] address boundary words");
        for (int i = 0; i < NI; i++) begin
            applyStimulus(i, 1'b1, 10'h3FF, 32'hA5A5A5A5, 1'b0);
            applyStimulus(i, 1'b1, 10'h000, 32'h5A5A5A5A, 1'b0);
            applyStimulus(i, 1'b0, 10'h3FF, 32'h0, 1'b0);
            applyStimulus(i, 1'b0, 10'h000, 32'h0, 1'b0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 10; n++) begin
                logic [AW-1:0] a;
                bit wr;
                case ($urandom_range(0, 2))
                    0:       a = '0;
                    1:       a = '1;
                    default: a = AW'($urandom);
                endcase
                wr = 1'($urandom_range(0, 1));
                if (!refValid[i][a]) wr = 1'b1;
                applyStimulus(i, wr, a, $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] reset during a read access");
        applyStimulus(2, 1'b1, 10'h155, 32'hCAFEF00D, 1'b0);
        applyStimulus(2, 1'b0, 10'h155, 32'h0, 1'b0);
        req[2] = 1'b1; reqWr[2] = 1'b0; reqAddr[2] = 10'h155;
        tick();
        req[2] = 1'b0;
        tick();
        checkOutput("midReadRdLow", 32'(rdN[2]), 32'd0);
        #2;
        rstN[2] = 1'b0;
        #1;
        checkOutput("midRstStrobes", 32'({csN[2], rdN[2], wrN[2]}), 32'd7);
        checkOutput("midRstRdy", 32'(reqRdy[2]), 32'd1);
        checkOutput("midRstRData", rData[2], 32'd0);
        ackSeen = 0;
        repeat (4) begin
            tick();
            if (ack[2]) ackSeen++;
        end
        rstN[2] = 1'b1;
        repeat (3) begin
            tick();
            if (ack[2]) ackSeen++;
        end
        checkOutput("midRstNoAck", 32'(ackSeen), 32'd0);
        checkOutput("postRstRdy", 32'(reqRdy[2]), 32'd1);
        checkOutput("postRstRData", rData[2], 32'd0);
        refLast[2] = '0;
        applyStimulus(2, 1'b0, 10'h155, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
